// File: rtl/sr_pkg.sv
// Shared definitions for the SR command arbiter: FSM states and {s,r} command encodings.
package sr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first asserted req scanning from ptr+1 upward.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic [PW-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter issuing one SR command per two cycles onto a flat flag bank.
// Define SR_CMD_ARBITER_TOGGLE_EN to make S=R=1 toggle the flag instead of setting sticky err.
module sr_cmd_arbiter
  import sr_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               s,
  input  logic [NREQ-1:0]               r,
  input  logic [NREQ*$clog2(NFLAG)-1:0] addr,
  output logic [NREQ-1:0]               gnt,
  output logic [NFLAG-1:0]              q,
  output logic [NFLAG-1:0]              qb,
  output logic                          err
);

  localparam int AW = $clog2(NFLAG);
  localparam int PW = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  win_q, win_d;
  logic [NREQ-1:0]  pick;
  logic [NFLAG-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [PW-1:0]    win_idx;
  logic [AW-1:0]    cmd_addr;
  logic [1:0]       cmd;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_rr_pick (
    .req(req),
    .ptr(ptr_q),
    .win(pick)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q[i]) win_idx = PW'(i);
    end
  end

  // Command fields are taken live from the winner during ISSUE, not latched at arbitration.
  assign cmd      = {s[win_idx], r[win_idx]};
  assign cmd_addr = addr[win_idx*AW +: AW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    q_d     = q_q;
    err_d   = err_q;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          win_d   = pick;
        end
      end
      ISSUE: begin
        gnt     = win_q;
        state_d = IDLE;
        ptr_d   = win_idx;
        case (cmd)
          HOLD: ;
          SET:  q_d[cmd_addr] = 1'b1;
          CLR:  q_d[cmd_addr] = 1'b0;
          ILL: begin
`ifdef SR_CMD_ARBITER_TOGGLE_EN
            q_d[cmd_addr] = ~q_q[cmd_addr];
`else
            err_d = 1'b1;
`endif
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  assign q   = q_q;
  assign qb  = ~q_q;
  assign err = err_q;

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Scoreboard bench for sr_cmd_arbiter: stimulus queues expected grant/flag results, a monitor checks them.
module tb_sr_cmd_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int AW    = 3;

  typedef struct {
    logic [NREQ-1:0]  g;
    logic [NFLAG-1:0] q;
    logic             e;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      s = '0;
  logic [NREQ-1:0]      r = '0;
  logic [NREQ*AW-1:0]   addr = '0;
  logic [NREQ-1:0]      gnt;
  logic [NFLAG-1:0]     q;
  logic [NFLAG-1:0]     qb;
  logic                 err;
  logic [NREQ-1:0]      hold = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  sr_cmd_arbiter #(
    .NREQ (NREQ),
    .NFLAG(NFLAG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .s   (s),
    .r   (r),
    .addr(addr),
    .gnt (gnt),
    .q   (q),
    .qb  (qb),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_cmd(input logic [NREQ-1:0] g, input logic [NFLAG-1:0] qv, input logic e);
    exp_t x;
    x.g = g;
    x.q = qv;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    addr[i*AW +: AW] = v;
  endtask

  // Each requester not in hold drops req in the cycle after its grant.
  task automatic run_cycles(input int n);
    logic [NREQ-1:0] g;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      req = req & ~(g & ~hold);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '1;
    s    = '1;
    r    = '0;
    hold = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_q", 32'(q), 32'h00);
    check("rst_qb", 32'(qb), 32'hFF);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    s   = '0;
  endtask

  // Monitor: every grant pops one expectation; the flag state is checked one cycle later.
  initial begin
    exp_t e;
    logic [NFLAG-1:0] qbe;
    forever begin
      @(negedge clk);
      if (gnt !== '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got %b expected no grant at %0t", gnt, $time);
        end else begin
          e   = sb.pop_front();
          qbe = ~e.q;
          check("gnt", 32'(gnt), 32'(e.g));
          @(negedge clk);
          check("q", 32'(q), 32'(e.q));
          check("qb", 32'(qb), 32'(qbe));
          check("err", 32'(err), 32'(e.e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Single set from requester 0 on flag 3.
    req = 4'b0001; s = 4'b0001; r = '0; set_addr(0, 3'd3);
    expect_cmd(4'b0001, 8'h08, 1'b0);
    run_cycles(4);

    // Contention after reset: order 0,1,2,3.
    do_reset();
    req = 4'b1111; s = 4'b1111; r = '0;
    set_addr(0, 3'd0); set_addr(1, 3'd1); set_addr(2, 3'd2); set_addr(3, 3'd3);
    expect_cmd(4'b0001, 8'h01, 1'b0);
    expect_cmd(4'b0010, 8'h03, 1'b0);
    expect_cmd(4'b0100, 8'h07, 1'b0);
    expect_cmd(4'b1000, 8'h0F, 1'b0);
    run_cycles(9);

    // Fairness: requester 0 held, requester 2 still gets the second grant.
    hold = 4'b0001;
    req = 4'b0101; s = 4'b0101; r = '0; set_addr(0, 3'd4); set_addr(2, 3'd5);
    expect_cmd(4'b0001, 8'h1F, 1'b0);
    expect_cmd(4'b0100, 8'h3F, 1'b0);
    expect_cmd(4'b0001, 8'h3F, 1'b0);
    expect_cmd(4'b0001, 8'h2F, 1'b0);
    run_cycles(7);
    // Fourth grant is in its ISSUE cycle: drop req and switch to a clear; it must still execute.
    hold = '0; req = '0; s = '0; r = 4'b0001;
    run_cycles(3);
    r = '0;

    // Illegal S=R=1 on flag 3 (currently 1), then a legal command to show err is sticky.
    req = 4'b0010; s = 4'b0010; r = 4'b0010; set_addr(1, 3'd3);
`ifdef SR_CMD_ARBITER_TOGGLE_EN
    expect_cmd(4'b0010, 8'h27, 1'b0);
`else
    expect_cmd(4'b0010, 8'h2F, 1'b1);
`endif
    run_cycles(4);
    req = 4'b0010; s = 4'b0010; r = '0; set_addr(1, 3'd6);
`ifdef SR_CMD_ARBITER_TOGGLE_EN
    expect_cmd(4'b0010, 8'h67, 1'b0);
`else
    expect_cmd(4'b0010, 8'h6F, 1'b1);
`endif
    run_cycles(4);

    // Reset during ISSUE discards the command and restores requester 0 priority.
    req = 4'b0100; s = 4'b0100; r = '0; set_addr(2, 3'd7);
    expect_cmd(4'b0100, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; req = '0; s = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_q", 32'(q), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0101; s = 4'b0101; r = '0; set_addr(0, 3'd1); set_addr(2, 3'd2);
    expect_cmd(4'b0001, 8'h02, 1'b0);
    expect_cmd(4'b0100, 8'h06, 1'b0);
    run_cycles(6);

    req = '0; s = '0; r = '0;
    run_cycles(4);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
